// File: rtl/adpll_hop_seq_pkg.sv
// Shared types and constants for the ADPLL channel-hop sequencer:
// FCW width, ADPLL mode encodings, FSM states and the PRBS9 polynomial.
package adpll_hop_seq_pkg;

  localparam int ADPLL_FCWW = 32;

  typedef enum logic [1:0] {
    MODE_PD   = 2'd0,
    MODE_TEST = 2'd1,
    MODE_RX   = 2'd2,
    MODE_TX   = 2'd3
  } adpll_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TUNE,
    ST_DWELL,
    ST_GAP,
    ST_DONE
  } hop_state_e;

  localparam logic [8:0] PRBS9_SEED   = 9'h1FF;
  localparam int         PRBS9_TAP_HI = 8;
  localparam int         PRBS9_TAP_LO = 4;

  function automatic logic [8:0] prbs9_next(input logic [8:0] s);
    return {s[7:0], s[PRBS9_TAP_HI] ^ s[PRBS9_TAP_LO]};
  endfunction

endpackage

// File: rtl/adpll_hop_seq_prbs9.sv
// PRBS9 source (x^9 + x^5 + 1); serial output is the MSB, advanced one
// step per adv pulse. Only reset reseeds it, so the stream spans channels.
module adpll_hop_seq_prbs9
  import adpll_hop_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic adv,
  output logic bit_o
);

  logic [8:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv) lfsr_d = prbs9_next(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= PRBS9_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign bit_o = lfsr_q[PRBS9_TAP_HI];

endmodule

// File: rtl/adpll_hop_seq.sv
// Channel-hop / modulation sequencer: tunes each table entry, waits for lock
// with a timeout, dwells a number of symbols (PRBS9 in TX), then gaps.
//
// state    | meaning
// IDLE     | waiting for start, ADPLL powered down
// TUNE     | en=1 on current channel, waiting for channel_lock (timeout)
// DWELL    | locked, emitting dwell_sym symbols
// GAP      | en=0 for GAP_CYC cycles to force re-acquisition
// DONE     | one-cycle done pulse, then IDLE
module adpll_hop_seq
  import adpll_hop_seq_pkg::*;
#(
  parameter int FCWW    = ADPLL_FCWW,
  parameter int N_CH    = 4,
  parameter int SYM_DIV = 32,
  parameter int LOCK_TO = 4096,
  parameter int GAP_CYC = 8,
  localparam int NCW    = $clog2(N_CH + 1),
  localparam int CIW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 tx_sel,
  input  logic [NCW-1:0]       n_ch,
  input  logic [15:0]          dwell_sym,
  input  logic [N_CH*FCWW-1:0] fcw_tbl,
  input  logic                 channel_lock,
  output logic [FCWW-1:0]      fcw,
  output logic [1:0]           adpll_mode,
  output logic                 en,
  output logic                 data_mod,
  output logic                 sym_strobe,
  output logic [CIW-1:0]       ch_idx,
  output logic                 busy,
  output logic                 lock_err,
  output logic                 done
);

  localparam int TW = $clog2((LOCK_TO > GAP_CYC) ? LOCK_TO : GAP_CYC);
  localparam int DW = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
  localparam logic [TW-1:0]  TUNE_TC  = TW'(LOCK_TO - 1);
  localparam logic [TW-1:0]  GAP_TC   = TW'(GAP_CYC - 1);
  localparam logic [DW-1:0]  DIV_TC   = DW'(SYM_DIV - 1);
  localparam logic [NCW-1:0] N_CH_MAX = NCW'(N_CH);

  hop_state_e  state_q, state_d;
  adpll_mode_e mode_q, mode_d;
  logic [FCWW-1:0] fcw_q, fcw_d;
  logic            en_q, en_d;
  logic            data_mod_q, data_mod_d;
  logic            strobe_q, strobe_d;
  logic [CIW-1:0]  ch_idx_q, ch_idx_d;
  logic            busy_q, busy_d;
  logic            lock_err_q, lock_err_d;
  logic            done_q, done_d;
  logic            tx_q, tx_d;
  logic [NCW-1:0]  n_ch_q, n_ch_d;
  logic [15:0]     dwell_q, dwell_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [DW-1:0]   div_q, div_d;
  logic [15:0]     sym_left_q, sym_left_d;
  logic            prbs_adv, prbs_bit;
  logic [NCW-1:0]  n_ch_clamp;
  logic            last_ch;

  function automatic logic [FCWW-1:0] tbl_at(input logic [CIW-1:0] i);
    return fcw_tbl[i*FCWW +: FCWW];
  endfunction

  adpll_hop_seq_prbs9 u_prbs9 (
    .clk   (clk),
    .rst   (rst),
    .adv   (prbs_adv),
    .bit_o (prbs_bit)
  );

  assign n_ch_clamp = (n_ch > N_CH_MAX) ? N_CH_MAX : n_ch;
  assign last_ch    = (NCW'(ch_idx_q) + NCW'(1)) >= n_ch_q;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    fcw_d      = fcw_q;
    en_d       = en_q;
    data_mod_d = data_mod_q;
    strobe_d   = 1'b0;
    ch_idx_d   = ch_idx_q;
    lock_err_d = lock_err_q;
    done_d     = 1'b0;
    tx_d       = tx_q;
    n_ch_d     = n_ch_q;
    dwell_d    = dwell_q;
    tmr_d      = tmr_q;
    div_d      = div_q;
    sym_left_d = sym_left_q;
    prbs_adv   = 1'b0;

    if (stop) begin
      state_d    = ST_IDLE;
      en_d       = 1'b0;
      mode_d     = MODE_PD;
      data_mod_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start) begin
          tx_d       = tx_sel;
          n_ch_d     = n_ch_clamp;
          dwell_d    = dwell_sym;
          lock_err_d = 1'b0;
          if (n_ch_clamp == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            mode_d  = MODE_PD;
            en_d    = 1'b0;
          end else begin
            state_d  = ST_TUNE;
            ch_idx_d = '0;
            fcw_d    = tbl_at('0);
            mode_d   = tx_sel ? MODE_TX : MODE_RX;
            en_d     = 1'b1;
            tmr_d    = TUNE_TC;
          end
        end
        ST_TUNE: begin
          if (channel_lock) begin
            if (dwell_q == 16'd0) begin
              state_d = ST_GAP;
              en_d    = 1'b0;
              tmr_d   = GAP_TC;
            end else begin
              state_d    = ST_DWELL;
              div_d      = DIV_TC;
              sym_left_d = dwell_q;
            end
          end else if (tmr_q == '0) begin
            lock_err_d = 1'b1;
            state_d    = ST_GAP;
            en_d       = 1'b0;
            tmr_d      = GAP_TC;
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        // Lock loss wins over a coincident symbol wrap: no strobe for it.
        ST_DWELL: begin
          if (!channel_lock) begin
            lock_err_d = 1'b1;
            state_d    = ST_GAP;
            en_d       = 1'b0;
            tmr_d      = GAP_TC;
          end else if (div_q == '0) begin
            div_d      = DIV_TC;
            strobe_d   = 1'b1;
            data_mod_d = tx_q & prbs_bit;
            prbs_adv   = tx_q;
            if (sym_left_q == 16'd1) begin
              state_d = ST_GAP;
              en_d    = 1'b0;
              tmr_d   = GAP_TC;
            end else begin
              sym_left_d = sym_left_q - 16'd1;
            end
          end else begin
            div_d = div_q - DW'(1);
          end
        end
        ST_GAP: begin
          data_mod_d = 1'b0;
          if (tmr_q == '0) begin
            if (!last_ch) begin
              state_d  = ST_TUNE;
              ch_idx_d = ch_idx_q + CIW'(1);
              fcw_d    = tbl_at(ch_idx_q + CIW'(1));
              en_d     = 1'b1;
              tmr_d    = TUNE_TC;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              mode_d  = MODE_PD;
              en_d    = 1'b0;
            end
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_PD;
      fcw_q      <= '0;
      en_q       <= 1'b0;
      data_mod_q <= 1'b0;
      strobe_q   <= 1'b0;
      ch_idx_q   <= '0;
      busy_q     <= 1'b0;
      lock_err_q <= 1'b0;
      done_q     <= 1'b0;
      tx_q       <= 1'b0;
      n_ch_q     <= '0;
      dwell_q    <= '0;
      tmr_q      <= '0;
      div_q      <= '0;
      sym_left_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      fcw_q      <= fcw_d;
      en_q       <= en_d;
      data_mod_q <= data_mod_d;
      strobe_q   <= strobe_d;
      ch_idx_q   <= ch_idx_d;
      busy_q     <= busy_d;
      lock_err_q <= lock_err_d;
      done_q     <= done_d;
      tx_q       <= tx_d;
      n_ch_q     <= n_ch_d;
      dwell_q    <= dwell_d;
      tmr_q      <= tmr_d;
      div_q      <= div_d;
      sym_left_q <= sym_left_d;
    end
  end

  assign fcw        = fcw_q;
  assign adpll_mode = mode_q;
  assign en         = en_q;
  assign data_mod   = data_mod_q;
  assign sym_strobe = strobe_q;
  assign ch_idx     = ch_idx_q;
  assign busy       = busy_q;
  assign lock_err   = lock_err_q;
  assign done       = done_q;

endmodule
